// File: rtl/uart_rx_datapath.sv
// UART receiver timing and data path: 16x baud enable, RXD synchroniser, oversample/bit
// counters feeding uart_rx_ctrl, and an LSB-first deserialiser with ready/framing-error strobes.
module uart_rx_datapath #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    input  logic [1:0]           fsm_state,
    output logic                 RXD_SYNC,
    output logic                 BAUD_X16_EN,
    output logic                 over_sample_cnt_done,
    output logic                 bit_cnt_done,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_DATA_RDY,
    output logic                 FRM_ERR
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    rx_state_t            state;
    logic                 rxd_meta;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           os_cnt;
    logic [3:0]           os_target;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 os_done;
    logic                 data_sample;
    logic                 stop_sample;

    assign state = rx_state_t'(fsm_state);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxd_meta <= 1'b1;
            RXD_SYNC <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            RXD_SYNC <= rxd_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt     <= '0;
            BAUD_X16_EN <= 1'b0;
        end else begin
            BAUD_X16_EN <= (div_cnt == DIV_LAST);
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        os_target   = (state == ST_START) ? 4'd7 : 4'd15;
        os_done     = BAUD_X16_EN && (os_cnt == os_target) && (state != ST_IDLE);
        data_sample = os_done && (state == ST_DATA);
        stop_sample = os_done && (state == ST_STOP);
    end

    assign over_sample_cnt_done = os_done;
    assign bit_cnt_done         = data_sample && (bit_cnt == BIT_LAST);

    // Only IDLE clears os_cnt; a forced state jump without a done keeps counting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            os_cnt <= 4'd0;
        end else if (state == ST_IDLE) begin
            os_cnt <= 4'd0;
        end else if (BAUD_X16_EN) begin
            os_cnt <= os_done ? 4'd0 : os_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= 3'd0;
        end else if (state != ST_DATA) begin
            bit_cnt <= 3'd0;
        end else if (os_done) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? 3'd0 : bit_cnt + 3'd1;
        end
    end

    // The shift register is never cleared between frames; a full frame overwrites every bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
        end else if (data_sample) begin
            shreg <= {RXD_SYNC, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_DATA     <= '0;
            RX_DATA_RDY <= 1'b0;
            FRM_ERR     <= 1'b0;
        end else begin
            RX_DATA_RDY <= stop_sample && RXD_SYNC;
            FRM_ERR     <= stop_sample && !RXD_SYNC;
            if (stop_sample && RXD_SYNC) begin
                RX_DATA <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath: a behavioural uart_rx_ctrl drives fsm_state,
// directed and random frames are checked against expectations derived from the frame contents.
module tb_uart_rx_datapath;
    localparam int CLK_FREQ  = 16_000_000;
    localparam int BAUD_RATE = 250_000;
    localparam int DATA_BITS = 8;
    localparam int BIT_CLKS  = 64;

    logic       CLK;
    logic       RST;
    logic       RXD;
    logic [1:0] fsm_state;
    logic       RXD_SYNC;
    logic       BAUD_X16_EN;
    logic       over_sample_cnt_done;
    logic       bit_cnt_done;
    logic [7:0] RX_DATA;
    logic       RX_DATA_RDY;
    logic       FRM_ERR;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic       use_manual   = 1'b0;
    logic [1:0] manual_state = 2'd0;

    int         done_pos[$];
    int         bit_done_pos[$];
    logic [7:0] rdy_q[$];
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         act_ticks = 0;

    uart_rx_datapath #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .RXD                 (RXD),
        .fsm_state           (fsm_state),
        .RXD_SYNC            (RXD_SYNC),
        .BAUD_X16_EN         (BAUD_X16_EN),
        .over_sample_cnt_done(over_sample_cnt_done),
        .bit_cnt_done        (bit_cnt_done),
        .RX_DATA             (RX_DATA),
        .RX_DATA_RDY         (RX_DATA_RDY),
        .FRM_ERR             (FRM_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed no summary by time limit, required finish");
        $fatal(1, "timeout");
    end

    // Behavioural uart_rx_ctrl: decides at the falling edge, applies just after the rising edge.
    initial begin : ctrl_model
        logic [1:0] nxt;
        logic       prev_sync;
        fsm_state = 2'd0;
        prev_sync = 1'b1;
        forever begin
            @(negedge CLK);
            nxt = fsm_state;
            case (fsm_state)
                2'd0:    if (prev_sync && !RXD_SYNC) nxt = 2'd1;
                2'd1:    if (over_sample_cnt_done) nxt = RXD_SYNC ? 2'd0 : 2'd2;
                2'd2:    if (bit_cnt_done) nxt = 2'd3;
                default: if (over_sample_cnt_done) nxt = 2'd0;
            endcase
            prev_sync = RXD_SYNC;
            @(posedge CLK);
            #1;
            fsm_state = use_manual ? manual_state : (RST ? nxt : 2'd0);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!RST) begin
                act_ticks = 0;
            end else begin
                if (fsm_state == 2'd0) act_ticks = 0;
                else if (BAUD_X16_EN) act_ticks++;
                if (over_sample_cnt_done) done_pos.push_back(act_ticks);
                if (bit_cnt_done) bit_done_pos.push_back(done_pos.size());
                if (RX_DATA_RDY) rdy_q.push_back(RX_DATA);
                if (FRM_ERR) err_cnt++;
                if (RX_DATA_RDY && FRM_ERR) both_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RXD = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_clks(BIT_CLKS);
        end
        RXD = stop_bit;
        wait_clks(BIT_CLKS);
        RXD = 1'b1;
    endtask

    // A full frame gives 10 sample points: tick 8 (mid start) then every 16 ticks.
    task automatic check_frame(input string tag, input int b_done, input int b_bd, input bit timing);
        check({tag, "_done_cnt"}, done_pos.size() - b_done, 10);
        if (timing) begin
            for (int k = 0; k < 10 && b_done + k < done_pos.size(); k++)
                check($sformatf("%s_done%0d_tick", tag, k), done_pos[b_done + k], 8 + 16 * k);
        end
        check({tag, "_bitdone_cnt"}, bit_done_pos.size() - b_bd, 1);
        if (bit_done_pos.size() > b_bd)
            check({tag, "_bitdone_at"}, bit_done_pos[b_bd] - b_done, 9);
    endtask

    initial begin : stimulus
        int         b_done;
        int         b_bd;
        int         b_rdy;
        int         b_err;
        int         n_bad;
        int         seen;
        logic [7:0] exp_data;
        logic [7:0] byte_v;
        logic       stop_v;
        logic [7:0] exp_q[$];

        RXD = 1'b1;
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("rst_rxd_sync", 32'(RXD_SYNC), 1);
        check("rst_baud_en", 32'(BAUD_X16_EN), 0);
        check("rst_os_done", 32'(over_sample_cnt_done), 0);
        check("rst_bit_done", 32'(bit_cnt_done), 0);
        check("rst_rx_data", 32'(RX_DATA), 0);
        check("rst_rdy", 32'(RX_DATA_RDY), 0);
        check("rst_frm_err", 32'(FRM_ERR), 0);

        RST = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            check($sformatf("baud_en_c%0d", c), 32'(BAUD_X16_EN), 32'(c % 4 == 0));
        end

        // Frame 0xA5, good stop bit
        wait_clks(3);
        b_done = done_pos.size(); b_bd = bit_done_pos.size(); b_rdy = rdy_q.size(); b_err = err_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clks(16);
        check_frame("a5", b_done, b_bd, 1'b1);
        check("a5_rdy_cnt", rdy_q.size() - b_rdy, 1);
        if (rdy_q.size() > b_rdy) check("a5_rdy_data", 32'(rdy_q[b_rdy]), 32'h A5);
        check("a5_err_cnt", err_cnt - b_err, 0);
        check("a5_rx_data", 32'(RX_DATA), 32'hA5);

        // Same frame, stop bit low
        b_done = done_pos.size(); b_bd = bit_done_pos.size(); b_rdy = rdy_q.size(); b_err = err_cnt;
        send_frame(8'hA5, 1'b0);
        wait_clks(16);
        check_frame("ferr", b_done, b_bd, 1'b0);
        check("ferr_err_cnt", err_cnt - b_err, 1);
        check("ferr_rdy_cnt", rdy_q.size() - b_rdy, 0);
        check("ferr_rx_data", 32'(RX_DATA), 32'hA5);

        // False start: ctrl goes to START for 5 ticks then back to IDLE
        b_done = done_pos.size();
        manual_state = 2'd0;
        use_manual   = 1'b1;
        wait_clks(3);
        manual_state = 2'd1;
        seen = 0;
        for (int i = 0; i < 100 && seen < 5; i++) begin
            @(negedge CLK);
            if (fsm_state == 2'd1 && BAUD_X16_EN) seen++;
        end
        check("fs_ticks_seen", seen, 5);
        manual_state = 2'd0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge CLK);
            if (fsm_state == 2'd0) seen = 1;
        end
        check("fs_back_idle", seen, 1);
        check("fs_os_before_clear", 32'(dut.os_cnt), 5);
        @(negedge CLK);
        check("fs_os_cleared", 32'(dut.os_cnt), 0);
        check("fs_no_done", done_pos.size() - b_done, 0);
        use_manual = 1'b0;

        wait_clks(5);
        b_done = done_pos.size(); b_bd = bit_done_pos.size(); b_rdy = rdy_q.size();
        send_frame(8'h3C, 1'b1);
        wait_clks(16);
        check_frame("x3c", b_done, b_bd, 1'b0);
        check("x3c_rdy_cnt", rdy_q.size() - b_rdy, 1);
        if (rdy_q.size() > b_rdy) check("x3c_rdy_data", 32'(rdy_q[b_rdy]), 32'h3C);

        // Reset asserted during bit 4 of 0xFF
        b_rdy = rdy_q.size();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_clks(BIT_CLKS * 5 + 10);
                RST = 1'b0;
                #1;
                check("mr_rxd_sync", 32'(RXD_SYNC), 1);
                check("mr_baud_en", 32'(BAUD_X16_EN), 0);
                check("mr_os_done", 32'(over_sample_cnt_done), 0);
                check("mr_bit_done", 32'(bit_cnt_done), 0);
                check("mr_rx_data", 32'(RX_DATA), 0);
                check("mr_rdy", 32'(RX_DATA_RDY), 0);
                check("mr_frm_err", 32'(FRM_ERR), 0);
                wait_clks(5);
                RST = 1'b1;
            end
        join
        wait_clks(16);
        check("mr_no_rdy", rdy_q.size() - b_rdy, 0);

        b_done = done_pos.size(); b_bd = bit_done_pos.size(); b_rdy = rdy_q.size();
        send_frame(8'h00, 1'b1);
        wait_clks(16);
        check_frame("x00", b_done, b_bd, 1'b0);
        check("x00_rdy_cnt", rdy_q.size() - b_rdy, 1);
        check("x00_rx_data", 32'(RX_DATA), 0);

        // Back-to-back 0x55, 0xAA with one idle bit between
        b_done = done_pos.size(); b_bd = bit_done_pos.size(); b_rdy = rdy_q.size();
        send_frame(8'h55, 1'b1);
        wait_clks(BIT_CLKS);
        send_frame(8'hAA, 1'b1);
        wait_clks(16);
        check("b2b_done_cnt", done_pos.size() - b_done, 20);
        check("b2b_bitdone_cnt", bit_done_pos.size() - b_bd, 2);
        check("b2b_rdy_cnt", rdy_q.size() - b_rdy, 2);
        if (rdy_q.size() > b_rdy + 1) begin
            check("b2b_rdy0", 32'(rdy_q[b_rdy]), 32'h55);
            check("b2b_rdy1", 32'(rdy_q[b_rdy + 1]), 32'hAA);
        end

        // Random frames: good frames update the expected word, bad stop bits leave it alone
        exp_data = 8'hAA;
        n_bad    = 0;
        b_rdy    = rdy_q.size();
        b_err    = err_cnt;
        for (int f = 0; f < 6; f++) begin
            byte_v = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            wait_clks($urandom_range(1, 100));
            send_frame(byte_v, stop_v);
            wait_clks(16);
            if (stop_v) begin
                exp_data = byte_v;
                exp_q.push_back(byte_v);
            end else begin
                n_bad++;
            end
            check($sformatf("rnd%0d_rx_data", f), 32'(RX_DATA), 32'(exp_data));
        end
        check("rnd_rdy_cnt", rdy_q.size() - b_rdy, exp_q.size());
        check("rnd_err_cnt", err_cnt - b_err, n_bad);
        for (int i = 0; i < exp_q.size() && b_rdy + i < rdy_q.size(); i++)
            check($sformatf("rnd_rdy_data%0d", i), 32'(rdy_q[b_rdy + i]), 32'(exp_q[i]));

        check("rdy_err_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
